gain_serializer: RTL and testbench



---
 rtl/denoise_pkg.sv | 16 +
 rtl/word_mux.sv | 22 ++
 rtl/gain_serializer.sv | 122 ++++++++++++
 tb/tb_gain_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared constants and types for the RNN denoise core and its I/O adapters.
// Gains and features are raw IEEE-754 single-precision words carried as bits.
package denoise_pkg;

  localparam int unsigned FLOAT_W          = 32;
  localparam int unsigned N_GAIN           = 22;
  localparam int unsigned N_FEAT           = 42;
  localparam int unsigned GAIN_FRAME_WORDS = N_GAIN + 1;
  localparam int unsigned GAIN_IDX_W       = 5;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

endpackage

// File: rtl/word_mux.sv
// N-to-1 word selector over a flat word vector; word i lives at bits [i*W +: W].
// Out-of-range selects return zero.
module word_mux #(
  parameter int unsigned W    = 32,
  parameter int unsigned N    = 23,
  parameter int unsigned SELW = 5
) (
  input  logic [N*W-1:0] words_i,
  input  logic [SELW-1:0] sel_i,
  output logic [W-1:0]   word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_i == SELW'(i)) begin
        word_o = words_i[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/gain_serializer.sv
// Captures one gain frame (NGAIN gains + VAD word) in parallel and streams it out
// one word per accepted beat; a new frame may be captured on the last beat.
module gain_serializer
  import denoise_pkg::*;
#(
  parameter int unsigned FLOAT = FLOAT_W,
  parameter int unsigned NGAIN = N_GAIN,
  parameter int unsigned IDXW  = GAIN_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NGAIN*FLOAT-1:0] gains,
  input  logic [FLOAT-1:0]       vad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT-1:0]       out_data,
  output logic [IDXW-1:0]        out_index,
  output logic                   out_last
);

  localparam int unsigned NWORDS = NGAIN + 1;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NGAIN);

  ser_state_e              state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [NWORDS*FLOAT-1:0] frame_q, frame_d;
  logic [FLOAT-1:0]        data_q, data_d;
  logic                    last_q, last_d;
  logic [FLOAT-1:0]        next_word;
  logic                    capture;
  logic                    beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // The output word is registered from the next-state frame/index so that the
  // first word is already on out_data the cycle after capture.
  word_mux #(
    .W   (FLOAT),
    .N   (NWORDS),
    .SELW(IDXW)
  ) u_word_mux (
    .words_i(frame_d),
    .sel_i  (idx_d),
    .word_o (next_word)
  );

  always_comb begin
    capture = in_valid && in_ready;
    beat    = (state_q == SEND) && out_ready;
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
          frame_d = {vad, gains};
        end
      end
      SEND: begin
        if (beat) begin
          if (last_q) begin
            idx_d = '0;
            if (capture) begin
              frame_d = {vad, gains};
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    data_d = next_word;
    last_d = (state_d == SEND) && (idx_d == LastIdx);
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      SEND: begin
        in_ready  = last_q && out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
    out_data  = data_q;
    out_index = idx_q;
    out_last  = last_q;
  end

endmodule

// File: tb/tb_gain_serializer.sv
// Directed bench for gain_serializer: a queue-based frame model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_gain_serializer;

  localparam int unsigned FW = 32;
  localparam int unsigned NG = 22;
  localparam int unsigned IW = 5;

  typedef struct {
    logic [FW-1:0] data;
    int            index;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NG*FW-1:0] gains;
  logic [FW-1:0]    vad;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    out_data;
  logic [IW-1:0]    out_index;
  logic             out_last;

  int    errors = 0;
  int    checks = 0;
  int    beats_seen = 0;
  bit    armed = 1'b0;
  beat_t exp_q[$];

  gain_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .gains    (gains),
    .vad      (vad),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_in_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
  endfunction

  // Model: a frame is a list of 23 words; each accepted beat consumes one.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      bit cap;
      cap = in_valid && model_in_ready();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (cap) begin
        for (int k = 0; k <= NG; k++) begin
          beat_t b;
          b.data  = (k < NG) ? gains[k*FW +: FW] : vad;
          b.index = k;
          b.last  = (k == NG);
          exp_q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_in_ready()});
      if (exp_q.size() != 0 && out_valid) begin
        chk("data", out_data, exp_q[0].data);
        chk("index", {27'b0, out_index}, 32'(exp_q[0].index));
        chk("last", {31'b0, out_last}, {31'b0, exp_q[0].last});
        if (out_ready) beats_seen++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [31:0] base, input logic [31:0] step,
                           input logic [31:0] v);
    for (int k = 0; k < NG; k++) gains[k*FW +: FW] = base + 32'(k) * step;
    vad = v;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gains     = '0;
    vad       = '0;
    cyc();
    cyc();
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_index", {27'b0, out_index}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single frame with out_ready held high
    set_frame(32'h3F80_0000, 32'd1, 32'h3F00_0000);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i <= NG; i++) begin
      chk("sf_valid", {31'b0, out_valid}, 32'd1);
      if (i == 0) chk("sf_word0", out_data, 32'h3F80_0000);
      if (i == 21) chk("sf_word21", out_data, 32'h3F80_0015);
      if (i == NG) begin
        chk("sf_vad", out_data, 32'h3F00_0000);
        chk("sf_last", {31'b0, out_last}, 32'd1);
        chk("sf_lastidx", {27'b0, out_index}, 32'd22);
      end
      cyc();
    end
    chk("sf_idle24", {31'b0, out_valid}, 32'd0);

    // Backpressure: out_ready 1-high/2-low
    set_frame(32'h1000_0000, 32'd3, 32'h2000_0001);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    b0 = beats_seen;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      out_ready = (c % 3 == 0);
      cyc();
    end
    chk("bp_beats", 32'(beats_seen - b0), 32'd23);
    chk("bp_done", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    cyc();

    // Back-to-back: B captured exactly on A's last beat
    set_frame(32'hA000_0000, 32'd1, 32'hA0FF_FFFF);
    in_valid = 1'b1;
    b0 = beats_seen;
    cyc();
    set_frame(32'hB000_0000, 32'd2, 32'hB0FF_FFFF);
    for (int i = 1; i <= 2 * (NG + 1); i++) begin
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      if (i == 22) chk("b2b_notready", {31'b0, in_ready}, 32'd0);
      if (i == 23) chk("b2b_ready", {31'b0, in_ready}, 32'd1);
      if (i == 24) begin
        chk("b2b_bword0", out_data, 32'hB000_0000);
        chk("b2b_bidx0", {27'b0, out_index}, 32'd0);
      end
      cyc();
      if (i == 23) in_valid = 1'b0;
    end
    chk("b2b_beats", 32'(beats_seen - b0), 32'd46);
    chk("b2b_idle", {31'b0, out_valid}, 32'd0);

    // Input isolation: inputs scrambled after capture
    set_frame(32'h4000_0000, 32'd5, 32'h4100_0000);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      set_frame(32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
      if (i == 5) chk("iso_word5", out_data, 32'h4000_0019);
      if (i == NG) chk("iso_vad", out_data, 32'h4100_0000);
      cyc();
    end
    chk("iso_done", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at beat 10
    set_frame(32'h5000_0000, 32'd1, 32'h5100_0000);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (10) cyc();
    chk("mid_idx10", {27'b0, out_index}, 32'd10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_index", {27'b0, out_index}, 32'd0);
    set_frame(32'h6000_0000, 32'd1, 32'h6100_0000);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("mid_new_idx", {27'b0, out_index}, 32'd0);
    chk("mid_new_word", out_data, 32'h6000_0000);
    drain(40);

    // Reset has priority over a simultaneous capture
    set_frame(32'h7000_0000, 32'd1, 32'h7100_0000);
    rst = 1'b1;
    in_valid = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("prio_valid", {31'b0, out_valid}, 32'd0);
    cyc();
    chk("prio_valid2", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
